// File: rtl/bwt_mem_req_sched_if.sv
// Request/issue/response bundle between the BWT-extend pipeline, the scheduler and the DRAM port.
// master: pipeline + DRAM side; slave: the scheduler.
interface bwt_mem_req_sched_if #(
    parameter int TAG_W = 7
) ();
    logic             req_valid;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      req_addr_k;
    logic [31:0]      req_addr_l;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [31:0]      addr_k;
    logic [31:0]      addr_l;
    logic             DRAM_get;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_tag, req_addr_k, req_addr_l, mem_req_ready, DRAM_get,
        input  mem_req_valid, addr_k, addr_l, rsp_tag
    );

    modport slave (
        input  req_valid, req_tag, req_addr_k, req_addr_l, mem_req_ready, DRAM_get,
        output mem_req_valid, addr_k, addr_l, rsp_tag
    );
endinterface

// File: rtl/bwt_mem_req_sched.sv
// Occurrence-table lookup scheduler: request FIFO, capped outstanding DRAM reads, in-order tag return.
// Define BWT_SCHED_PERF_EN to add saturating performance counters (perf_* outputs).
module bwt_mem_req_sched #(
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 32,
    parameter int TAG_W           = 7,
    parameter int ALMOST_FULL     = 12
) (
    input  logic                Clk_32UI,
    input  logic                reset_BWT_extend,
    input  logic                batch_start,
    input  logic [8:0]          batch_size,
    bwt_mem_req_sched_if.slave  bus,
    output logic                stall,
    output logic                batch_done,
    output logic                busy,
    output logic [1:0]          err
`ifdef BWT_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_stall_cyc,
    output logic [6:0]          perf_max_outst
`endif
);
    localparam int FA = $clog2(FIFO_DEPTH);
    localparam int TA = $clog2(MAX_OUTSTANDING);
    localparam logic [FA:0] F_DEPTH = FIFO_DEPTH[FA:0];
    localparam logic [FA:0] AF_LVL  = ALMOST_FULL[FA:0];
    localparam logic [TA:0] MAX_OUT = MAX_OUTSTANDING[TA:0];

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  size_q, size_d;
    logic [8:0]  rsp_cnt_q, rsp_cnt_d;
    logic [FA:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [TA:0] t_wr_q, t_wr_d, t_rd_q, t_rd_d;
    logic        stall_q, stall_d;
    logic [1:0]  err_q, err_d;

    logic [TAG_W-1:0] fifo_tag_q [FIFO_DEPTH];
    logic [31:0]      fifo_k_q   [FIFO_DEPTH];
    logic [31:0]      fifo_l_q   [FIFO_DEPTH];
    logic [TAG_W-1:0] tq_q       [MAX_OUTSTANDING];

    logic [FA:0] fifo_cnt, fifo_cnt_d;
    logic [TA:0] outst, outst_d;
    logic        full, fifo_nempty, req_valid_c, issue, push, get_ok;

    // Occupancies come from the pointers; the extra MSB separates full from empty.
    assign fifo_cnt    = f_wr_q - f_rd_q;
    assign outst       = t_wr_q - t_rd_q;
    assign full        = (fifo_cnt == F_DEPTH);
    assign fifo_nempty = (fifo_cnt != '0);
    assign req_valid_c = (state_q == S_RUN) && fifo_nempty && (outst < MAX_OUT);
    assign issue       = req_valid_c && bus.mem_req_ready;
    assign push        = bus.req_valid && !full && (state_q != S_DONE);
    assign get_ok      = bus.DRAM_get && (outst != '0);

    always_comb begin
        f_wr_d     = f_wr_q + (FA+1)'(push);
        f_rd_d     = f_rd_q + (FA+1)'(issue);
        t_wr_d     = t_wr_q + (TA+1)'(issue);
        t_rd_d     = t_rd_q + (TA+1)'(get_ok);
        fifo_cnt_d = f_wr_d - f_rd_d;
        outst_d    = t_wr_d - t_rd_d;
        // Look-ahead so stall reflects the occupancy the pipeline sees next cycle.
        stall_d    = (fifo_cnt_d >= AF_LVL) || (outst_d == MAX_OUT);
        err_d      = err_q | {bus.DRAM_get && (outst == '0),
                              bus.req_valid && (full || (state_q == S_DONE))};
        size_d     = size_q;
        rsp_cnt_d  = rsp_cnt_q;
        state_d    = state_q;
        if ((state_q == S_RUN) && get_ok) begin
            rsp_cnt_d = rsp_cnt_q + 9'd1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (batch_start) begin
                    state_d   = S_RUN;
                    size_d    = batch_size;
                    rsp_cnt_d = '0;
                end
            end
            S_RUN: begin
                if ((rsp_cnt_d == size_q) && (outst_d == '0)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_32UI) begin
        if (reset_BWT_extend) begin
            state_q   <= S_IDLE;
            size_q    <= '0;
            rsp_cnt_q <= '0;
            f_wr_q    <= '0;
            f_rd_q    <= '0;
            t_wr_q    <= '0;
            t_rd_q    <= '0;
            stall_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            rsp_cnt_q <= rsp_cnt_d;
            f_wr_q    <= f_wr_d;
            f_rd_q    <= f_rd_d;
            t_wr_q    <= t_wr_d;
            t_rd_q    <= t_rd_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge Clk_32UI) begin
        if (push) begin
            fifo_tag_q[f_wr_q[FA-1:0]] <= bus.req_tag;
            fifo_k_q[f_wr_q[FA-1:0]]   <= bus.req_addr_k;
            fifo_l_q[f_wr_q[FA-1:0]]   <= bus.req_addr_l;
        end
        if (issue) begin
            tq_q[t_wr_q[TA-1:0]] <= fifo_tag_q[f_rd_q[FA-1:0]];
        end
    end

    assign bus.mem_req_valid = req_valid_c;
    assign bus.addr_k        = fifo_nempty ? fifo_k_q[f_rd_q[FA-1:0]] : '0;
    assign bus.addr_l        = fifo_nempty ? fifo_l_q[f_rd_q[FA-1:0]] : '0;
    assign bus.rsp_tag       = (outst != '0) ? tq_q[t_rd_q[TA-1:0]] : '0;
    assign stall             = stall_q;
    assign err               = err_q;
    assign batch_done        = (state_q == S_DONE);
    assign busy              = (state_q != S_IDLE);

`ifdef BWT_SCHED_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [6:0]  perf_max_q, perf_max_d;

    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        perf_max_d   = perf_max_q;
        if (batch_start) begin
            perf_issue_d = '0;
            perf_stall_d = '0;
            perf_max_d   = '0;
        end else begin
            if (issue && (perf_issue_q != '1)) perf_issue_d = perf_issue_q + 32'd1;
            if (stall_q && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
            if (7'(outst) > perf_max_q) perf_max_d = 7'(outst);
        end
    end

    always_ff @(posedge Clk_32UI) begin
        if (reset_BWT_extend) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
            perf_max_q   <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
            perf_max_q   <= perf_max_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cyc = perf_stall_q;
    assign perf_max_outst = perf_max_q;
`endif
endmodule

// File: tb/tb_bwt_mem_req_sched.sv
// Bench for bwt_mem_req_sched: directed scenarios then randomized traffic, every cycle compared
// against a queue-based reference model of the scheduler's rules.
module tb_bwt_mem_req_sched;
    localparam int FD = 16;
    localparam int MO = 4;
    localparam int TW = 7;
    localparam int AF = 12;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       batch_start;
    logic [8:0] batch_size;
    logic       stall, batch_done, busy;
    logic [1:0] err;

    always #5 clk = ~clk;

    bwt_mem_req_sched_if #(.TAG_W(TW)) bus ();

    bwt_mem_req_sched #(
        .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .TAG_W(TW), .ALMOST_FULL(AF)
    ) dut (
        .Clk_32UI(clk), .reset_BWT_extend(rst), .batch_start(batch_start),
        .batch_size(batch_size), .bus(bus), .stall(stall), .batch_done(batch_done),
        .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [31:0]   k;
        logic [31:0]   l;
    } ent_t;

    // Reference model: pending requests, issued-but-unanswered tags, batch phase.
    ent_t          mq[$];
    logic [TW-1:0] mt[$];
    int            m_phase = P_IDLE;
    int            m_size = 0;
    int            m_rsp = 0;
    logic [1:0]    m_err = 2'b00;
    logic          m_stall = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic [31:0] hs_k[$];
    int          hs_c[$];

    task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
        end
    endtask

    task automatic clr();
        rst = 1'b0; batch_start = 1'b0; batch_size = '0;
        bus.req_valid = 1'b0; bus.req_tag = '0; bus.req_addr_k = '0; bus.req_addr_l = '0;
        bus.mem_req_ready = 1'b0; bus.DRAM_get = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete(); mt.delete();
        m_phase = P_IDLE; m_size = 0; m_rsp = 0; m_err = 2'b00; m_stall = 1'b0;
    endtask

    // One clock: compare outputs with the model, advance the model with this cycle's inputs.
    task automatic tick();
        logic          ev, iss, gok, pok;
        logic [31:0]   ek, el;
        logic [TW-1:0] et;
        ent_t          e;
        #2;
        ev = (m_phase == P_RUN) && (mq.size() > 0) && (mt.size() < MO);
        ek = (mq.size() > 0) ? mq[0].k : 32'd0;
        el = (mq.size() > 0) ? mq[0].l : 32'd0;
        et = (mt.size() > 0) ? mt[0] : '0;
        chk("mem_req_valid", bus.mem_req_valid, ev);
        chk("addr_k", bus.addr_k, ek);
        chk("addr_l", bus.addr_l, el);
        chk("rsp_tag", bus.rsp_tag, et);
        chk("stall", stall, m_stall);
        chk("batch_done", batch_done, m_phase == P_DONE);
        chk("busy", busy, m_phase != P_IDLE);
        chk("err", err, m_err);
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            hs_k.push_back(bus.addr_k);
            hs_c.push_back(cyc);
        end
        if (batch_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst) begin
            model_reset();
        end else begin
            iss = ev && bus.mem_req_ready;
            gok = bus.DRAM_get && (mt.size() > 0);
            pok = bus.req_valid && (m_phase != P_DONE) && (mq.size() < FD);
            if (bus.DRAM_get && (mt.size() == 0)) m_err[1] = 1'b1;
            if (bus.req_valid && !pok) m_err[0] = 1'b1;
            if (gok) void'(mt.pop_front());
            if (iss) begin
                mt.push_back(mq[0].tag);
                void'(mq.pop_front());
            end
            if (pok) begin
                e.tag = bus.req_tag; e.k = bus.req_addr_k; e.l = bus.req_addr_l;
                mq.push_back(e);
            end
            if (gok && (m_phase == P_RUN)) m_rsp = (m_rsp + 1) % 512;
            m_stall = (mq.size() >= AF) || (mt.size() == MO);
            case (m_phase)
                P_IDLE: if (batch_start) begin
                    m_phase = P_RUN; m_size = int'(batch_size); m_rsp = 0;
                end
                P_RUN: if ((m_rsp == m_size) && (mt.size() == 0)) m_phase = P_DONE;
                default: m_phase = P_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_req(input int tag, input logic [31:0] k, input logic [31:0] l);
        bus.req_valid = 1'b1; bus.req_tag = TW'(tag); bus.req_addr_k = k; bus.req_addr_l = l;
    endtask

    task automatic start_batch(input int sz);
        rst = 1'b1; tick(); clr();
        batch_start = 1'b1; batch_size = 9'(sz); tick(); batch_start = 1'b0;
        hs_k.delete(); hs_c.delete();
    endtask

    initial begin
        int p0, g_last, bs;
        clr();
        rst = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;

        // Reset state, then a three-request batch.
        tick();
        start_batch(3);
        bus.mem_req_ready = 1'b1;
        p0 = cyc;
        for (int i = 0; i < 3; i++) begin
            push_req(i, 32'h1000 + i, 32'h2000 + i);
            tick();
        end
        bus.req_valid = 1'b0;
        repeat (3) tick();
        chk("t1_hs_count", hs_k.size(), 3);
        for (int i = 0; i < 3; i++) chk("t1_hs_order", hs_k[i], 32'h1000 + i);
        chk("t1_first_latency", hs_c[0] - p0, 1);
        bus.mem_req_ready = 1'b0;
        done_cnt = 0;
        g_last = 0;
        for (int i = 0; i < 3; i++) begin
            bus.DRAM_get = 1'b1;
            chk("t1_rsp_tag", bus.rsp_tag, i);
            g_last = cyc;
            tick();
        end
        bus.DRAM_get = 1'b0;
        repeat (4) tick();
        chk("t1_done_once", done_cnt, 1);
        chk("t1_done_latency", done_cyc - g_last, 1);
        chk("t1_busy_idle", busy, 0);

        // FIFO fill with DRAM refusing: stall at 12, overflow on the 17th push.
        start_batch(100);
        for (int i = 0; i < 17; i++) begin
            push_req(i, 32'h3000 + i, 32'h4000 + i);
            tick();
            if (i == 11) chk("t2_stall_after_12", stall, 1);
        end
        bus.req_valid = 1'b0;
        tick();
        chk("t2_err_overflow", err, 2'b01);
        for (int c = 0; c < 40; c++) begin
            bus.mem_req_ready = 1'b1;
            bus.DRAM_get = (mt.size() > 0);
            tick();
        end
        clr();
        chk("t2_issued_count", hs_k.size(), 16);
        for (int i = 0; i < 16; i++) chk("t2_issued_order", hs_k[i], 32'h3000 + i);

        // Outstanding cap, then one response frees a slot.
        start_batch(6);
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_req(16 + i, 32'h5000 + i, 32'h6000 + i);
            tick();
        end
        bus.req_valid = 1'b0;
        repeat (4) tick();
        chk("t3_issue_cap", hs_k.size(), 4);
        chk("t3_valid_low", bus.mem_req_valid, 0);
        chk("t3_stall", stall, 1);
        bus.DRAM_get = 1'b1;
        tick();
        bus.DRAM_get = 1'b0;
        tick();
        chk("t3_fifth_issue", hs_k.size(), 5);

        // Issue and response in the same cycle with two outstanding.
        start_batch(8);
        for (int i = 0; i < 4; i++) begin
            push_req(32 + i, 32'h7000 + i, 32'h8000 + i);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick(); tick();
        bus.mem_req_ready = 1'b0;
        tick();
        chk("t4_head_before", bus.rsp_tag, 32);
        bus.mem_req_ready = 1'b1; bus.DRAM_get = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0; bus.DRAM_get = 1'b0;
        chk("t4_head_after", bus.rsp_tag, 33);
        chk("t4_stall_clear", stall, 0);
        tick();

        // Response with nothing outstanding.
        rst = 1'b1; tick(); clr();
        bus.DRAM_get = 1'b1;
        tick();
        bus.DRAM_get = 1'b0;
        chk("t5_err_underflow", err, 2'b10);
        tick();

        // Reset mid-batch, then an empty batch.
        start_batch(9);
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_req(48 + i, 32'h9000 + i, 32'hA000 + i);
            tick();
        end
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        clr();
        chk("t6_rst_valid", bus.mem_req_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_rsp_tag", bus.rsp_tag, 0);
        chk("t6_rst_addr_k", bus.addr_k, 0);
        batch_start = 1'b1; batch_size = 9'd0;
        bs = cyc;
        tick();
        batch_start = 1'b0;
        done_cnt = 0;
        repeat (4) tick();
        chk("t6_done_once", done_cnt, 1);
        chk("t6_done_latency", done_cyc - bs, 2);

        // Randomized traffic against the model.
        for (int b = 0; b < 6; b++) begin
            start_batch($urandom_range(1, 40));
            for (int c = 0; c < 400; c++) begin
                bus.req_valid = (($urandom_range(0, 3) != 0) && !m_stall) || ($urandom_range(0, 19) == 0);
                bus.req_tag = TW'($urandom);
                bus.req_addr_k = $urandom;
                bus.req_addr_l = $urandom;
                bus.mem_req_ready = ($urandom_range(0, 3) != 0);
                bus.DRAM_get = ($urandom_range(0, 2) == 0);
                batch_start = ($urandom_range(0, 30) == 0);
                batch_size = 9'($urandom_range(0, 20));
                tick();
            end
            clr();
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
